// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit that owns HI/LO.
// Optional MD_EARLY_TERM_EN: trivial operands skip the iteration phase.
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             hilo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;
  logic               hilo_write_q, hilo_write_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               early_term;
  logic [WIDTH:0]     acc_ext, addend_ext, booth_sum;
  logic [2*WIDTH:0]   booth_next;
  logic [WIDTH:0]     rem_shift, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH:0]   div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Booth accumulator is widened by one bit so that adding or subtracting
  // INT_MIN keeps the true sign for the arithmetic shift.
  always_comb begin
    a_abs = a[WIDTH-1] ? -a : a;
    b_abs = b[WIDTH-1] ? -b : b;

    early_term = 1'b0;
`ifdef MD_EARLY_TERM_EN
    early_term = op ? ((b != '0) && (a_abs < b_abs)) : ((a == '0) || (b == '0));
`endif

    acc_ext    = {work_q[2*WIDTH], work_q[2*WIDTH:WIDTH+1]};
    addend_ext = {mcand_q[WIDTH-1], mcand_q};
    case (work_q[1:0])
      2'b01:   booth_sum = acc_ext + addend_ext;
      2'b10:   booth_sum = acc_ext - addend_ext;
      default: booth_sum = acc_ext;
    endcase
    booth_next = {booth_sum, work_q[WIDTH:1]};

    rem_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, mcand_q};
    rem_ge    = (rem_shift >= {1'b0, mcand_q});
    div_next  = rem_ge ? {rem_sub, work_q[WIDTH-2:0], 1'b1}
                       : {rem_shift, work_q[WIDTH-2:0], 1'b0};

    quo_fix = (sign_a_q ^ sign_b_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix = sign_a_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer: captures operands at start, iterates, fixes signs, then pulses done.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    mcand_d      = mcand_q;
    work_d       = work_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    div0_d       = 1'b0;
    hilo_write_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = hi_wdata;
        if (wr_lo) lo_d = lo_wdata;
        if (start) begin
          op_d     = op;
          sign_a_d = a[WIDTH-1];
          sign_b_d = b[WIDTH-1];
          mcand_d  = op ? b_abs : b;
          cnt_d    = CNT_W'(WIDTH);
          work_d   = op ? {{(WIDTH+1){1'b0}}, a_abs} : {{WIDTH{1'b0}}, a, 1'b0};
          if (op && (b == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            div0_d  = 1'b1;
          end else if (early_term) begin
            state_d = S_FIX;
            cnt_d   = '0;
            work_d  = op ? {1'b0, a_abs, {WIDTH{1'b0}}} : '0;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        work_d = op_q ? div_next : booth_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = work_q[2*WIDTH:WIDTH+1];
          lo_d = work_q[WIDTH:1];
        end
        done_d       = 1'b1;
        hilo_write_d = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= 1'b0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      mcand_q      <= '0;
      work_q       <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div0_q       <= 1'b0;
      hilo_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      mcand_q      <= mcand_d;
      work_q       <= work_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      div0_q       <= div0_d;
      hilo_write_q <= hilo_write_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign div0       = div0_q;
  assign hilo_write = hilo_write_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: scoreboard of expected HI/LO/flags/latency.
module tb_mult_div_seq;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         wr_hi = 1'b0;
  logic         wr_lo = 1'b0;
  logic [W-1:0] a = '0, b = '0, hi_wdata = '0, lo_wdata = '0;
  logic         busy, done, div0, hilo_write;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    logic         hw;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] model_hi = '0, model_lo = '0;

  logic [W-1:0] got_hi, got_lo, got_hi0, got_lo0;
  logic         got_div0, got_hw, got_busy0;
  int           got_lat;

  mult_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .div0(div0), .hilo_write(hilo_write),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Drives one operation, pushes its model result and samples the completion cycle.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic wh, input logic wl,
                        input logic [W-1:0] hwd, input logic [W-1:0] lwd);
    exp_t   e;
    longint sx, sy, p, q, r, ax, ay;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ax = (sx < 0) ? -sx : sx;
    ay = (sy < 0) ? -sy : sy;
    if (wh) model_hi = hwd;
    if (wl) model_lo = lwd;
    e.div0 = 1'b0;
    e.hw   = 1'b1;
    e.lat  = 34;
    if (o == 1'b0) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.div0 = 1'b1;
      e.hw   = 1'b0;
      e.lat  = 1;
      e.hi   = model_hi;
      e.lo   = model_lo;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
`ifdef MD_EARLY_TERM_EN
    if ((o == 1'b0 && (x == '0 || y == '0)) || (o == 1'b1 && y != '0 && ax < ay)) e.lat = 2;
`else
    if (ax < 0 || ay < 0) e.lat = 0;
`endif
    model_hi = e.hi;
    model_lo = e.lo;
    sb_q.push_back(e);

    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    wr_hi = wh; wr_lo = wl; hi_wdata = hwd; lo_wdata = lwd;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; a = ~x; b = ~y;
    got_busy0 = busy;
    got_hi0   = hi;
    got_lo0   = lo;
    got_lat   = 1;
    while (!done && got_lat < 100) begin
      @(negedge clock);
      got_lat++;
    end
    got_hi   = hi;
    got_lo   = lo;
    got_div0 = div0;
    got_hw   = hilo_write;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if ({div0, hilo_write} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {div0, hilo_write}); end
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("[TB] FAIL reset_hilo: got %h/%h expected 0/0", hi, lo); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult();
    logic [W-1:0] xs[3] = '{32'h0000_0007, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [W-1:0] ys[3] = '{32'hFFFF_FFFD, 32'h09AB_CDEF, 32'hFFFF_FFFF};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, xs[i], ys[i], 1'b0, 1'b0, '0, '0);
      e = sb_q.pop_front();
      checks++; if (got_busy0 !== 1'b1) begin errors++; $display("[TB] FAIL mult_busy[%0d]: got %b expected 1", i, got_busy0); end
      checks++; if (got_hi !== e.hi) begin errors++; $display("[TB] FAIL mult_hi[%0d]: got %h expected %h", i, got_hi, e.hi); end
      checks++; if (got_lo !== e.lo) begin errors++; $display("[TB] FAIL mult_lo[%0d]: got %h expected %h", i, got_lo, e.lo); end
      checks++; if ({got_div0, got_hw} !== {e.div0, e.hw}) begin errors++; $display("[TB] FAIL mult_flags[%0d]: got %b expected %b", i, {got_div0, got_hw}, {e.div0, e.hw}); end
      checks++; if (got_lat !== e.lat) begin errors++; $display("[TB] FAIL mult_latency[%0d]: got %0d expected %0d", i, got_lat, e.lat); end
    end
  endtask

  task automatic test_div();
    logic [W-1:0] xs[4] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C};
    logic [W-1:0] ys[4] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, xs[i], ys[i], 1'b0, 1'b0, '0, '0);
      e = sb_q.pop_front();
      checks++; if (got_hi !== e.hi) begin errors++; $display("[TB] FAIL div_hi[%0d]: got %h expected %h", i, got_hi, e.hi); end
      checks++; if (got_lo !== e.lo) begin errors++; $display("[TB] FAIL div_lo[%0d]: got %h expected %h", i, got_lo, e.lo); end
      checks++; if ({got_div0, got_hw} !== {e.div0, e.hw}) begin errors++; $display("[TB] FAIL div_flags[%0d]: got %b expected %b", i, {got_div0, got_hw}, {e.div0, e.hw}); end
      checks++; if (got_lat !== e.lat) begin errors++; $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", i, got_lat, e.lat); end
    end
  endtask

  task automatic test_div0();
    exp_t e;
    run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, '0, '0);
    e = sb_q.pop_front();
    checks++; if (got_div0 !== 1'b1) begin errors++; $display("[TB] FAIL div0_flag: got %b expected 1", got_div0); end
    checks++; if (got_hw !== 1'b0) begin errors++; $display("[TB] FAIL div0_hilo_write: got %b expected 0", got_hw); end
    checks++; if (got_lat !== e.lat) begin errors++; $display("[TB] FAIL div0_latency: got %0d expected %0d", got_lat, e.lat); end
    checks++; if (got_hi !== e.hi || got_lo !== e.lo) begin errors++; $display("[TB] FAIL div0_hilo_kept: got %h/%h expected %h/%h", got_hi, got_lo, e.hi, e.lo); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] xs[2] = '{32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] ys[2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic         ops[2] = '{1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], xs[i], ys[i], 1'b0, 1'b0, '0, '0);
      e = sb_q.pop_front();
      checks++; if (got_hi !== e.hi) begin errors++; $display("[TB] FAIL ovf_hi[%0d]: got %h expected %h", i, got_hi, e.hi); end
      checks++; if (got_lo !== e.lo) begin errors++; $display("[TB] FAIL ovf_lo[%0d]: got %h expected %h", i, got_lo, e.lo); end
      checks++; if (got_lat !== e.lat) begin errors++; $display("[TB] FAIL ovf_latency[%0d]: got %0d expected %0d", i, got_lat, e.lat); end
    end
  endtask

  task automatic test_early_term();
    logic [W-1:0] xs[2] = '{32'd3, 32'd0};
    logic [W-1:0] ys[2] = '{32'd10, 32'd5};
    logic         ops[2] = '{1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], xs[i], ys[i], 1'b0, 1'b0, '0, '0);
      e = sb_q.pop_front();
      checks++; if (got_hi !== e.hi || got_lo !== e.lo) begin errors++; $display("[TB] FAIL early_hilo[%0d]: got %h/%h expected %h/%h", i, got_hi, got_lo, e.hi, e.lo); end
      checks++; if (got_lat !== e.lat) begin errors++; $display("[TB] FAIL early_latency[%0d]: got %0d expected %0d", i, got_lat, e.lat); end
      checks++; if (got_hw !== e.hw) begin errors++; $display("[TB] FAIL early_hilo_write[%0d]: got %b expected %b", i, got_hw, e.hw); end
    end
  endtask

  task automatic test_wr();
    exp_t e;
    @(negedge clock);
    wr_hi = 1'b1; hi_wdata = 32'hCAFE_0001; wr_lo = 1'b1; lo_wdata = 32'hBEEF_0002;
    model_hi = 32'hCAFE_0001; model_lo = 32'hBEEF_0002;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b0;
    checks++; if (hi !== model_hi || lo !== model_lo) begin errors++; $display("[TB] FAIL wr_idle: got %h/%h expected %h/%h", hi, lo, model_hi, model_lo); end
    run_op(1'b1, 32'd100, 32'd7, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    e = sb_q.pop_front();
    checks++; if (got_hi0 !== 32'h1234_5678 || got_lo0 !== 32'h9ABC_DEF0) begin errors++; $display("[TB] FAIL wr_with_start: got %h/%h expected 12345678/9abcdef0", got_hi0, got_lo0); end
    checks++; if (got_hi !== e.hi || got_lo !== e.lo) begin errors++; $display("[TB] FAIL wr_start_result: got %h/%h expected %h/%h", got_hi, got_lo, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    run_op(1'b0, 32'd11, 32'd13, 1'b0, 1'b0, '0, '0);
    e = sb_q.pop_front();
    checks++; if (got_lo !== e.lo) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", got_lo, e.lo); end
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
    @(negedge clock);
    start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start_in_done: got busy=%b done=%b expected 0/0", busy, done); end
    run_op(1'b1, 32'hFFFF_FF9C, 32'd9, 1'b0, 1'b0, '0, '0);
    e = sb_q.pop_front();
    checks++; if (got_hi !== e.hi || got_lo !== e.lo) begin errors++; $display("[TB] FAIL b2b_second: got %h/%h expected %h/%h", got_hi, got_lo, e.hi, e.lo); end
    checks++; if (got_lat !== e.lat) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", got_lat, e.lat); end
  endtask

  task automatic test_abort();
    int pulses;
    logic [W-1:0] hi_before;
    hi_before = model_hi;
    @(negedge clock);
    start = 1'b1; op = 1'b0; a = 32'd7; b = 32'd5;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    start = 1'b1; op = 1'b1; b = 32'd0; wr_hi = 1'b1; hi_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0; wr_hi = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_restart_ignored: got busy=%b done=%b expected 1/0", busy, done); end
    checks++; if (hi !== hi_before) begin errors++; $display("[TB] FAIL abort_wr_hi_ignored: got %h expected %h", hi, hi_before); end
    repeat (9) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    model_hi = '0; model_lo = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("[TB] FAIL abort_hilo: got %h/%h expected 0/0", hi, lo); end
    pulses = 0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_overflow();
    test_early_term();
    test_wr();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
